pipe_stage_skid: RTL and testbench

//  Parametrised ready/valid pipeline stage register for the ID->EX boundary and other stage boundaries.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stage_skid.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: field widths, field offsets
// inside the control and payload vectors, and the skid stage occupancy encoding.
package pipe_pkg;

    localparam int CTRL_W_DEF    = 8;
    localparam int PAYLOAD_W_DEF = 122;
    localparam int CNT_W_DEF     = 32;

    // Control field: W[1:0] | M[1:0] | E[3:0]
    localparam int CTRL_E_LSB = 0;
    localparam int CTRL_M_LSB = 4;
    localparam int CTRL_W_LSB = 6;

    // Payload: rd1 | rd2 | immed | funct | shamt | rs | rt | rd
    localparam int PL_RD_LSB    = 0;
    localparam int PL_RT_LSB    = 5;
    localparam int PL_RS_LSB    = 10;
    localparam int PL_SHAMT_LSB = 15;
    localparam int PL_FUNCT_LSB = 20;
    localparam int PL_IMMED_LSB = 26;
    localparam int PL_RD2_LSB   = 58;
    localparam int PL_RD1_LSB   = 90;

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones, clears on rst.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count register with saturation at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Ready/valid stage register with a 2-entry (main + skid) buffer and flush.
// Optional perf counters (stall_cnt, bubble_cnt) when STAGE_PERF_CNT_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
`ifdef STAGE_PERF_CNT_EN
    ,
    parameter int CNT_W     = CNT_W_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef STAGE_PERF_CNT_EN
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
`endif
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [PAYLOAD_W-1:0] out_data
);

    stage_state_e           r_state;
    stage_state_e           w_state_nxt;
    logic [CTRL_W-1:0]      r_main_ctrl;
    logic [CTRL_W-1:0]      r_skid_ctrl;
    logic [PAYLOAD_W-1:0]   r_main_data;
    logic [PAYLOAD_W-1:0]   r_skid_data;
    logic                   w_main_valid;
    logic                   w_skid_valid;
    logic                   w_accept;
    logic                   w_drain;
    logic                   w_load_main_in;
    logic                   w_load_main_skid;
    logic                   w_load_skid;

    assign w_main_valid = (r_state == ONE) || (r_state == FULL);
    assign w_skid_valid = (r_state == FULL);
    assign in_ready     = !w_skid_valid && !rst;
    assign w_accept     = in_valid && in_ready;
    assign w_drain      = w_main_valid && out_ready;

    assign out_valid    = w_main_valid;
    assign out_ctrl     = w_main_valid ? r_main_ctrl : {CTRL_W{1'b0}};
    assign out_data     = r_main_data;

    // Occupancy register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and datapath load selects; flush wins over any transfer
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = EMPTY;
                    end else begin
                        w_state_nxt = ONE;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end else begin
                        w_state_nxt = FULL;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Main and skid entry registers; ctrl always moves with its payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_ctrl <= {CTRL_W{1'b0}};
            r_main_data <= {PAYLOAD_W{1'b0}};
            r_skid_ctrl <= {CTRL_W{1'b0}};
            r_skid_data <= {PAYLOAD_W{1'b0}};
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl;
                r_main_data <= in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end else begin
                r_main_ctrl <= r_main_ctrl;
                r_main_data <= r_main_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end else begin
                r_skid_ctrl <= r_skid_ctrl;
                r_skid_data <= r_skid_data;
            end
        end
    end

`ifdef STAGE_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_main_valid && !out_ready),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (!w_main_valid),
        .o_cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, hand sequences
// for stall/flush/bubble, then random traffic against a FIFO reference model.
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 122;
`ifdef STAGE_PERF_CNT_EN
    localparam int CNTW    = 4;
    localparam int CNT_MAX = 15;
`else
    localparam int CNT_MAX = 15;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef STAGE_PERF_CNT_EN
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .CTRL_W    (CW),
        .PAYLOAD_W (DW)
`ifdef STAGE_PERF_CNT_EN
        ,
        .CNT_W     (CNTW)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef STAGE_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data)
    );

    // Reference model: the stage is a 2-deep FIFO whose head is the output.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          mq[$];
    logic [DW-1:0] m_last = '0;
    int            m_stall = 0;
    int            m_bubble = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   ov;
        bit   acc;
        bit   drn;
        ent_t e;
        ov = (mq.size() > 0);
        if (rst) begin
            mq.delete();
            m_last   = '0;
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            drn = ov && out_ready;
            if (ov && !out_ready && m_stall < CNT_MAX) m_stall++;
            if (!ov && m_bubble < CNT_MAX) m_bubble++;
            if (drn) e = mq.pop_front();
            if (flush) mq.delete();
            else if (acc) begin
                e.c = in_ctrl;
                e.d = in_data;
                mq.push_back(e);
            end
            if (mq.size() > 0) m_last = mq[0].d;
        end
    endtask

    task automatic check_model();
        logic [CW-1:0] ec;
        ec = (mq.size() > 0) ? mq[0].c : '0;
        chk("m_out_valid", 128'(out_valid), 128'(mq.size() > 0));
        chk("m_out_ctrl",  128'(out_ctrl),  128'(ec));
        chk("m_out_data",  128'(out_data),  128'(m_last));
        chk("m_in_ready",  128'(in_ready),  128'(!rst && mq.size() < 2));
`ifdef STAGE_PERF_CNT_EN
        chk("m_stall_cnt",  128'(stall_cnt),  128'(m_stall));
        chk("m_bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
`endif
    endtask

    // Drive one cycle of inputs, advance the model and the DUT by one edge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy,
                       input bit do_model_chk);
        rst = r; flush = f; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
        model_step();
        @(posedge clk);
        #1;
        if (do_model_chk) check_model();
    endtask

    typedef struct {
        logic          r;
        logic          f;
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [DW-1:0] e_od;
        logic          e_ir;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [127:0] rnd;
        logic         r_r;
        logic         r_f;
        logic         r_iv;
        logic         r_or;

        // Reset with in_valid high, release, then stream 1..10 with ctrl A5
        for (int i = 0; i < 3; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b1, 8'hA5, 122'd99, 1'b1, 1'b0, 8'h00, 122'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 122'd0, 1'b1, 1'b0, 8'h00, 122'd0, 1'b1};
        for (int k = 1; k <= 10; k++)
            tbl[3+k] = '{1'b0, 1'b0, 1'b1, 8'hA5, DW'(k), 1'b1, 1'b1, 8'hA5, DW'(k), 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 122'd0, 1'b1, 1'b0, 8'h00, 122'd10, 1'b1};

        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy, 1'b0);
            chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_ctrl", i),  128'(out_ctrl),  128'(tbl[i].e_oc));
            chk($sformatf("vec%0d_out_data", i),  128'(out_data),  128'(tbl[i].e_od));
            chk($sformatf("vec%0d_in_ready", i),  128'(in_ready),  128'(tbl[i].e_ir));
        end

        // Backpressure: 3 pushes with out_ready low, then release
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 122'd1, 1'b0, 1'b1);
        chk("bp_in_ready_c1", 128'(in_ready), 128'(1'b1));
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 122'd2, 1'b0, 1'b1);
        chk("bp_in_ready_c2", 128'(in_ready), 128'(1'b0));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h3C, 122'd3, 1'b0, 1'b1);
            chk("bp_hold_data", 128'(out_data), 128'd1);
            chk("bp_hold_ready", 128'(in_ready), 128'(1'b0));
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 122'd3, 1'b1, 1'b1);
        chk("bp_rel_data2", 128'(out_data), 128'd2);
        cyc(1'b0, 1'b0, 1'b1, 8'h3C, 122'd3, 1'b1, 1'b1);
        chk("bp_rel_data3", 128'(out_data), 128'd3);
        chk("bp_rel_valid3", 128'(out_valid), 128'(1'b1));
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 122'd0, 1'b1, 1'b1);
        chk("bp_drained", 128'(out_valid), 128'(1'b0));

        // Flush while FULL with in_valid high
        cyc(1'b0, 1'b0, 1'b1, 8'h77, 122'd7, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h88, 122'd8, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'h99, 122'd9, 1'b0, 1'b1);
        chk("fl_out_valid", 128'(out_valid), 128'(1'b0));
        chk("fl_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("fl_in_ready",  128'(in_ready),  128'(1'b1));
        chk("fl_out_data",  128'(out_data),  128'd7);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 122'd0, 1'b1, 1'b1);
            chk("fl_no_ghost", 128'(out_valid), 128'(1'b0));
        end

        // Bubble: one entry then 4 idle cycles
        cyc(1'b0, 1'b0, 1'b1, 8'h11, 122'h55, 1'b1, 1'b1);
        chk("bub_entry", 128'(out_data), 128'h55);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 122'd0, 1'b1, 1'b1);
            chk("bub_ctrl", 128'(out_ctrl), 128'd0);
            chk("bub_data", 128'(out_data), 128'h55);
        end

`ifdef STAGE_PERF_CNT_EN
        // Counter saturation and clear on reset
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 122'd0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'h42, 122'd5, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b0, 1'b0, 8'h00, 122'd0, 1'b0, 1'b1);
        chk("cnt_stall_sat", 128'(stall_cnt), 128'd15);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 122'd0, 1'b0, 1'b1);
        chk("cnt_stall_rst", 128'(stall_cnt), 128'd0);
        chk("cnt_bubble_rst", 128'(bubble_cnt), 128'd0);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            rnd  = {$urandom(), $urandom(), $urandom(), $urandom()};
            r_r  = ($urandom_range(0, 119) == 0);
            r_f  = ($urandom_range(0, 15) == 0);
            r_iv = ($urandom_range(0, 3) != 0);
            r_or = ($urandom_range(0, 2) != 0);
            cyc(r_r, r_f, r_iv, 8'($urandom()), rnd[DW-1:0], r_or, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
